// File: rtl/lockin_pkg.sv
// Shared definitions for the lock-in demodulator: FSM encoding and the
// width derivations used by the top level.
package lockin_pkg;

    // One accepted sample walks IDLE -> MUL_I -> MUL_Q -> ACC -> IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_I = 2'd1,
        MUL_Q = 2'd2,
        ACC   = 2'd3
    } state_t;

    // Full-precision product width of sample times reference.
    function automatic int calc_p_w(input int data_w, input int ref_w);
        return data_w + ref_w;
    endfunction

    // Accumulator width: product plus growth from summing 2^dec_log2 terms.
    function automatic int calc_acc_w(input int p_w, input int dec_log2);
        return p_w + dec_log2;
    endfunction

endpackage

// File: rtl/mult_signed.sv
// Signed multiplier with one registered output stage. The demodulator
// shares one instance between the in-phase and quadrature products.
module mult_signed #(
    parameter int A_W = 16,
    parameter int B_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [A_W-1:0]      a,
    input  logic signed [B_W-1:0]      b,
    output logic signed [A_W+B_W-1:0]  p
);

    localparam int P_W = A_W + B_W;

    // Register the full-precision product; operands are sign-extended first.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            p <= '0;
        end else begin
            p <= P_W'(a) * P_W'(b);
        end
    end

endmodule

// File: rtl/lockin_demod.sv
// Lock-in demodulator: multiplies each sample by a cos/sin reference pair,
// integrates 2^DEC_LOG2 products per channel and emits rounded I/Q results.
module lockin_demod
    import lockin_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REF_W    = 16,
    parameter int DEC_LOG2 = 2,
    parameter int OUT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [REF_W-1:0]  in_sin,
    input  logic signed [REF_W-1:0]  in_cos,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_i,
    output logic signed [OUT_W-1:0]  out_q,
    output logic [15:0]              out_cnt
);

    localparam int P_W   = calc_p_w(DATA_W, REF_W);
    localparam int ACC_W = calc_acc_w(P_W, DEC_LOG2);
    // A zero-width counter is not representable; one bit that always
    // wraps to zero gives the dump-every-sample behaviour for DEC_LOG2=0.
    localparam int CNT_W = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DEC_LOG2) - 1);

    if (OUT_W > ACC_W) begin : g_bad_width
        $error("lockin_demod: OUT_W (%0d) exceeds ACC_W (%0d)", OUT_W, ACC_W);
    end

    state_t                    state;
    logic signed [DATA_W-1:0]  x_reg;
    logic signed [REF_W-1:0]   sin_reg;
    logic signed [REF_W-1:0]   cos_reg;
    logic signed [REF_W-1:0]   mult_b;
    logic signed [P_W-1:0]     p;
    logic signed [ACC_W-1:0]   p_ext;
    logic signed [ACC_W-1:0]   acc_i;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   sum_q;
    logic [CNT_W-1:0]          cnt;
    logic [OUT_W-1:0]          rnd_i;
    logic [OUT_W-1:0]          rnd_q;
    logic                      accept;

    // NOTE: in_ready is gated by rst because the async reset parks the FSM
    // in IDLE, which would otherwise advertise readiness during reset.
    assign in_ready = (state == IDLE) && !clr && !rst;
    assign accept   = in_valid && in_ready;

    // The shared multiplier sees cos during MUL_I and sin during MUL_Q.
    assign mult_b = (state == MUL_Q) ? sin_reg : cos_reg;

    mult_signed #(
        .A_W(DATA_W),
        .B_W(REF_W)
    ) u_mult (
        .clk(clk),
        .rst(rst),
        .a  (x_reg),
        .b  (mult_b),
        .p  (p)
    );

    assign p_ext = ACC_W'(p);
    // Q total including the product being accumulated in ACC this cycle.
    assign sum_q = acc_q + p_ext;

    if (OUT_W == ACC_W) begin : g_no_round
        assign rnd_i = acc_i;
        assign rnd_q = sum_q;
    end else begin : g_round
        localparam int RB = ACC_W - OUT_W - 1;
        localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

        // Keep the top OUT_W bits, round half up, clamp the one overflow case.
        function automatic logic [OUT_W-1:0] round_sat(input logic [ACC_W-1:0] v);
            logic [OUT_W-1:0] top;
            top = v[ACC_W-1 -: OUT_W];
            if (v[RB] && (top == OUT_MAX)) begin
                return OUT_MAX;
            end
            return top + OUT_W'(v[RB]);
        endfunction

        assign rnd_i = round_sat(acc_i);
        assign rnd_q = round_sat(sum_q);
    end

    // Sequencer, accumulators and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x_reg     <= '0;
            sin_reg   <= '0;
            cos_reg   <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            out_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                // Abort: drop the in-flight sample but keep the last results.
                state <= IDLE;
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            x_reg   <= in_data;
                            sin_reg <= in_sin;
                            cos_reg <= in_cos;
                            state   <= MUL_I;
                        end
                    end
                    MUL_I: begin
                        state <= MUL_Q;
                    end
                    MUL_Q: begin
                        acc_i <= acc_i + p_ext;
                        state <= ACC;
                    end
                    ACC: begin
                        state <= IDLE;
                        if (cnt == CNT_LAST) begin
                            out_i     <= rnd_i;
                            out_q     <= rnd_q;
                            out_valid <= 1'b1;
                            out_cnt   <= out_cnt + 16'd1;
                            acc_i     <= '0;
                            acc_q     <= '0;
                            cnt       <= '0;
                        end else begin
                            acc_q <= sum_q;
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lockin_demod.sv
// Self-checking bench for lockin_demod: a transaction-level model predicts
// readiness and results every cycle; directed cases pin known values.
module tb_lockin_demod;

    localparam int DATA_W   = 16;
    localparam int REF_W    = 16;
    localparam int DEC_LOG2 = 2;
    localparam int OUT_W    = 16;
    localparam int ACC_W    = DATA_W + REF_W + DEC_LOG2;
    localparam int SH       = ACC_W - OUT_W;
    localparam int GROUP    = 1 << DEC_LOG2;
    localparam longint OUT_MAX = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint OUT_MIN = -OUT_MAX - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [DATA_W-1:0] in_data = '0;
    logic signed [REF_W-1:0]  in_sin = '0;
    logic signed [REF_W-1:0]  in_cos = '0;
    logic out_valid;
    logic signed [OUT_W-1:0] out_i;
    logic signed [OUT_W-1:0] out_q;
    logic [15:0] out_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    lockin_demod #(
        .DATA_W  (DATA_W),
        .REF_W   (REF_W),
        .DEC_LOG2(DEC_LOG2),
        .OUT_W   (OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sin   (in_sin),
        .in_cos   (in_cos),
        .out_valid(out_valid),
        .out_i    (out_i),
        .out_q    (out_q),
        .out_cnt  (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference scaling: divide by 2^SH rounding half up, then clamp.
    function automatic longint scale(input longint v);
        longint r;
        if (SH == 0) r = v;
        else r = (v + (longint'(1) << (SH > 0 ? SH - 1 : 0))) >>> SH;
        if (r > OUT_MAX) r = OUT_MAX;
        if (r < OUT_MIN) r = OUT_MIN;
        return r;
    endfunction

    // Transaction model: a sample occupies the block for 4 cycles from
    // acceptance; it is committed 3 edges later unless clr intervenes.
    int     m_busy  = 0;
    longint m_x     = 0;
    longint m_c     = 0;
    longint m_s     = 0;
    longint m_sum_i = 0;
    longint m_sum_q = 0;
    int     m_n     = 0;
    bit     m_valid = 1'b0;
    longint m_i     = 0;
    longint m_q     = 0;
    int     m_cnt   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_sum_i = 0; m_sum_q = 0; m_n = 0;
            m_valid = 1'b0; m_i = 0; m_q = 0; m_cnt = 0;
        end else begin
            m_valid = 1'b0;
            if (clr) begin
                m_busy = 0; m_sum_i = 0; m_sum_q = 0; m_n = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_sum_i += m_x * m_c;
                    m_sum_q += m_x * m_s;
                    m_n++;
                    if (m_n == GROUP) begin
                        m_i = scale(m_sum_i);
                        m_q = scale(m_sum_q);
                        m_valid = 1'b1;
                        m_cnt = (m_cnt + 1) % 65536;
                        m_sum_i = 0; m_sum_q = 0; m_n = 0;
                    end
                end
            end else if (in_valid) begin
                m_busy = 3;
                m_x = in_data; m_c = in_cos; m_s = in_sin;
            end
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        check("in_ready",  longint'(in_ready),  longint'(!rst && !clr && m_busy == 0));
        check("out_valid", longint'(out_valid), longint'(m_valid));
        check("out_i",     longint'(out_i),     m_i);
        check("out_q",     longint'(out_q),     m_q);
        check("out_cnt",   longint'(out_cnt),   longint'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int c, input int s);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'(x);
        in_cos   = 16'(c);
        in_sin   = 16'(s);
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("send timeout", 0, 1);
    endtask

    task automatic send_group(input int x, input int c, input int s);
        for (int k = 0; k < GROUP; k++) send(x, c, s);
    endtask

    task automatic wait_out(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check({name, " out_valid seen"}, longint'(seen), 1);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int pulses;
        int ready_cnt;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("reset in_ready",  longint'(in_ready),  0);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_cnt",   longint'(out_cnt),   0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // In-phase full-scale group
        send_group(16384, 16384, 0);
        wait_out("i_full");
        check("i_full out_i",   longint'(out_i),   4096);
        check("i_full out_q",   longint'(out_q),   0);
        check("i_full out_cnt", longint'(out_cnt), 1);
        tick();

        // Quadrature negative group
        send_group(-16384, 0, 16384);
        wait_out("q_neg");
        check("q_neg out_q", longint'(out_q), -4096);
        check("q_neg out_i", longint'(out_i), 0);
        tick();

        // Rounding boundary: exactly half an LSB rounds up, a quarter does not
        send_group(256, 128, 0);
        wait_out("round_half");
        check("round_half out_i", longint'(out_i), 1);
        tick();
        send_group(256, 64, 0);
        wait_out("round_quarter");
        check("round_quarter out_i", longint'(out_i), 0);
        tick();

        // Abort in MUL_Q of the 4th sample suppresses the result
        do_clr();
        for (int k = 0; k < GROUP - 1; k++) send(16384, 16384, 0);
        send(16384, 16384, 0);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("clr suppresses out_valid", longint'(pulses), 0);
        tick();
        send_group(16384, 16384, 0);
        wait_out("after_clr");
        check("after_clr out_i", longint'(out_i), 4096);
        tick();

        // Randomized traffic with occasional aborts
        for (int cyc = 0; cyc < 800; cyc++) begin
            int sel;
            in_valid = ($urandom_range(0, 9) < 7);
            clr      = ($urandom_range(0, 39) == 0);
            sel      = $urandom_range(0, 7);
            in_data  = (sel == 0) ? 16'sh8000 : (sel == 1) ? 16'sh7FFF : 16'($urandom);
            in_cos   = (sel == 2) ? 16'sh8000 : 16'($urandom);
            in_sin   = (sel == 3) ? 16'sh7FFF : 16'($urandom);
            tick();
        end
        in_valid = 1'b0;
        clr = 1'b0;
        repeat (6) tick();

        // Continuous in_valid: ready one cycle in four
        do_clr();
        in_valid = 1'b1;
        in_data = 16'sd1000; in_cos = 16'sd2000; in_sin = -16'sd3000;
        ready_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) ready_cnt++;
            tick();
        end
        in_valid = 1'b0;
        check("ready duty 1 in 4", longint'(ready_cnt), 10);
        repeat (6) tick();

        // Asynchronous reset mid-ACC clears outputs before the next edge
        send(1000, 1000, 1000);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("async rst out_valid", longint'(out_valid), 0);
        check("async rst out_i",     longint'(out_i),     0);
        check("async rst out_q",     longint'(out_q),     0);
        check("async rst out_cnt",   longint'(out_cnt),   0);
        check("async rst in_ready",  longint'(in_ready),  0);
        #2 rst = 1'b0;
        tick();

        // Clean group after reset
        send_group(16384, 16384, 0);
        wait_out("post_rst");
        check("post_rst out_i",   longint'(out_i),   4096);
        check("post_rst out_cnt", longint'(out_cnt), 1);
        tick();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lockin_demod.md
LOCKIN_DEMOD -- requirements
Module: lockin_demod

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, signal sample width; REF_W, default 16, sin/cos reference width; DEC_LOG2, default 2, log2 of samples integrated per output; OUT_W, default 16, output width.
REQ-002 SHALL derive P_W = DATA_W+REF_W and ACC_W = P_W+DEC_LOG2 as localparams, and SHALL reject OUT_W > ACC_W at elaboration.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 clr  in  1  synchronous abort: restart integration.
REQ-006 in_valid  in  1  sample/reference present.
REQ-007 in_ready  out  1  block accepts a sample this cycle.
REQ-008 in_data  in  DATA_W  signed two's-complement signal sample.
REQ-009 in_sin, in_cos  in  REF_W each  signed reference pair, phase-aligned with in_data.
REQ-010 out_valid  out  1  one-cycle pulse, out_i/out_q updated.
REQ-011 out_i, out_q  out  OUT_W each  signed in-phase (x*cos) and quadrature (x*sin) results.
REQ-012 out_cnt  out  16  wrapping count of results produced.

Function
REQ-013 FSM states SHALL be IDLE, MUL_I, MUL_Q, ACC; in_ready SHALL be 1 only in IDLE with clr=0.
REQ-014 IDLE: in_valid&in_ready SHALL register in_data/in_sin/in_cos and go to MUL_I; otherwise stay in IDLE.
REQ-015 MUL_I SHALL register p = x*cos (P_W, signed) and go to MUL_Q.
REQ-016 MUL_Q SHALL register p = x*sin, add the I product sign-extended into acc_i, and go to ACC.
REQ-017 ACC SHALL add the Q product into acc_q, increment the sample counter (DEC_LOG2 bits, wraps), and go to IDLE.
REQ-018 Both products SHALL use one shared multiplier instance, time-multiplexed.
REQ-019 When the sample counter equals 2^DEC_LOG2-1 in ACC, the block SHALL load out_i/out_q from the accumulators including the current sample, clear both accumulators to 0, and pulse out_valid in the following cycle.
REQ-020 Output scaling SHALL take bits [ACC_W-1 : ACC_W-OUT_W], rounding half up via bit ACC_W-OUT_W-1 (none when OUT_W=ACC_W), saturating to the signed OUT_W limits if rounding overflows.
REQ-021 Accepted-sample-to-out_valid latency SHALL be 4 cycles for the dumping sample; maximum throughput one sample per 4 cycles.
REQ-022 out_i/out_q SHALL hold their value between out_valid pulses.
REQ-023 out_cnt SHALL increment on each out_valid and wrap 0xFFFF->0.
REQ-024 clr in any state SHALL force IDLE, zero accumulators and sample counter, and discard the in-flight sample; it SHALL suppress that sample's out_valid; out_i/out_q/out_cnt SHALL be kept.
REQ-025 clr and in_valid in the same cycle: clr SHALL win, no sample accepted.
REQ-026 DEC_LOG2=0 SHALL output every sample.

Reset
REQ-027 rst SHALL asynchronously force: state IDLE, in_ready 0 while rst is high, accumulators 0, sample counter 0, out_valid 0, out_i 0, out_q 0, out_cnt 0.
REQ-028 The first acceptance SHALL occur no earlier than the first rising edge after rst deasserts.

Structure
REQ-029 The FSM state encoding and the ACC_W/P_W derivation functions SHALL live in the shared package lockin_pkg.
REQ-030 The multiplier SHALL be a separate sub-module, mult_signed (parametrised A_W, B_W, one registered stage); the rest stays in lockin_demod.

Verification (DATA_W=16, REF_W=16, DEC_LOG2=2, OUT_W=16)
REQ-031 Four samples x=16384, cos=16384, sin=0 -> one out_valid, out_i=4096, out_q=0, out_cnt=1.
REQ-032 Four samples x=-16384, sin=16384, cos=0 -> out_q=-4096, out_i=0.
REQ-033 Four samples x=256, cos=128 (acc=2^17) -> out_i=1 (round half up); x=256, cos=64 -> out_i=0.
REQ-034 clr asserted in MUL_Q of the 4th sample -> no out_valid; the next four samples x=16384, cos=16384 -> out_i=4096.
REQ-035 in_valid held high continuously -> in_ready asserted exactly 1 cycle in 4; rst pulsed mid-ACC -> all outputs 0 immediately, before the next clock edge.
